reg_write_arbiter: RTL and testbench
====================================

REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: consecutive cycles a pending multicycle write may be refused before it is forced through.
REQ-002 clk  input  1  system clock; all state updates on posedge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 p0_valid  input  1  pipeline writeback request.
REQ-005 p0_rd  input  5  pipeline destination register.
REQ-006 p0_data  input  32  pipeline write data.
REQ-007 p0_stall  output  1  combinational; pipeline SHALL hold its p0 request (valid, rd, data) unchanged next cycle.
REQ-008 m_valid  input  1  multicycle-unit writeback request.
REQ-009 m_rd  input  5  multicycle-unit destination register.
REQ-010 m_data  input  32  multicycle-unit write data.
REQ-011 m_ready  output  1  combinational; m request accepted this cycle when m_valid && m_ready.
REQ-012 iss_valid  input  1  multicycle op issued this cycle.
REQ-013 iss_rd  input  5  destination of the issued op.
REQ-014 busy  output  32  registered scoreboard, bit i = register i has an outstanding multicycle write.
REQ-015 rf_we  output  1  registered register-file write enable.
REQ-016 rf_rd  output  5  registered register-file write address.
REQ-017 rf_wdata  output  32  registered register-file write data.

Function
REQ-018 Exactly one write per cycle: grant goes to p0 or m, never both.
REQ-019 force_m = m_valid && (wait_cnt == STARVE_LIMIT).
REQ-020 p0_hazard = p0_valid && p0_rd != 0 && busy[p0_rd], which blocks p0 on a WAW conflict.
REQ-021 p0 granted iff p0_valid && !force_m && !p0_hazard.
REQ-022 m granted iff m_valid && !(p0 granted).
REQ-023 m_ready = m granted.
REQ-024 p0_stall = p0_valid && !(p0 granted).
REQ-025 Winner's rd/data appear on rf_rd/rf_wdata one cycle after grant (latency 1), with rf_we=1.
REQ-026 Write to rd=0 SHALL complete its handshake but register rf_we=0, rf_rd=0, rf_wdata=0.
REQ-027 With no grant in a cycle, next cycle rf_we=0, rf_rd=0, rf_wdata=0; the idle address is forced to 0 because the register file acts on rf_rd even when rf_we=0.
REQ-028 wait_cnt, 0..STARVE_LIMIT, saturating:
- increments when m_valid && !m_ready;
- clears to 0 when m granted or m_valid=0.
REQ-029 Scoreboard set: iss_valid && iss_rd != 0 sets busy[iss_rd] next cycle.
REQ-030 Scoreboard clear: m granted clears busy[m_rd] next cycle.
REQ-031 Same index set and cleared in one cycle: set wins.
REQ-032 busy[0] SHALL always read 0.
REQ-033 iss_valid to an already-busy register leaves it busy; no counting, so one clear frees it.
REQ-034 m request whose rd is not busy SHALL still be accepted and written.

Reset
REQ-035 rst_n low SHALL asynchronously force:
- rf_we=0, rf_rd=0, rf_wdata=0;
- busy=0;
- wait_cnt=0.
REQ-036 During reset, the combinational outputs SHALL read p0_stall=p0_valid && p0_hazard (evaluating to 0 since busy=0) and m_ready=m_valid && !p0_valid.
REQ-037 Reset mid-operation discards pending scoreboard state; no write SHALL issue in the first cycle after release unless granted in that cycle.

Verification
REQ-038 p0_valid=1, rd=5, data=0xAA; m_valid=0 -> p0_stall=0; next cycle rf_we=1, rf_rd=5, rf_wdata=0xAA.
REQ-039 p0 and m both valid every cycle, STARVE_LIMIT=4 -> m_ready low for 4 cycles, high on 5th with p0_stall=1; wait_cnt returns to 0.
REQ-040 iss_valid rd=7 -> busy[7]=1; p0 rd=7 -> p0_stall=1 until m rd=7 accepted; busy[7]=0 the cycle after acceptance, then p0 granted.
REQ-041 iss_valid rd=9 same cycle m rd=9 granted -> busy[9] stays 1; iss_valid rd=0 -> busy stays 0.
REQ-042 p0 rd=0, data=0x55 -> p0_stall=0; next cycle rf_we=0, rf_rd=0, rf_wdata=0; an idle cycle also gives rf_rd=0.
REQ-043 busy[3]=1, wait_cnt=2, rst_n pulsed low mid-cycle -> immediately busy=0, rf_we=0; wait_cnt restarts from 0.

Source files
------------

// File: rtl/reg_write_arbiter_if.sv
// Register-file writeback bus: pipeline port, multicycle port,
// issue scoreboard feed and the registered register-file write.
interface reg_write_arbiter_if;
    logic        p0_valid;
    logic [4:0]  p0_rd;
    logic [31:0] p0_data;
    logic        p0_stall;
    logic        m_valid;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    logic        m_ready;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic [31:0] busy;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wdata;

    modport master (
        output p0_valid, p0_rd, p0_data,
        input  p0_stall,
        output m_valid, m_rd, m_data,
        input  m_ready,
        output iss_valid, iss_rd,
        input  busy, rf_we, rf_rd, rf_wdata
    );

    modport slave (
        input  p0_valid, p0_rd, p0_data,
        output p0_stall,
        input  m_valid, m_rd, m_data,
        output m_ready,
        input  iss_valid, iss_rd,
        output busy, rf_we, rf_rd, rf_wdata
    );
endinterface

// File: rtl/reg_write_arbiter.sv
// Single-port register-file write arbiter between the pipeline and a
// multicycle unit, with a WAW scoreboard and starvation forcing.
module reg_write_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input logic clk,
    input logic rst_n,
    reg_write_arbiter_if.slave bus
);
    localparam int CW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] wait_cnt;
    logic [CW-1:0] wait_nxt;
    logic [31:0]   busy_q;
    logic [31:0]   busy_d;
    logic          force_m;
    logic          p0_hazard;
    logic          p0_grant;
    logic          m_grant;
    logic          wr_en;
    logic [4:0]    wr_rd;
    logic [31:0]   wr_data;
    logic          rf_we_q;
    logic [4:0]    rf_rd_q;
    logic [31:0]   rf_wdata_q;

    always_comb begin
        force_m   = bus.m_valid && (wait_cnt == LIMIT);
        p0_hazard = bus.p0_valid && (bus.p0_rd != 5'd0)
                    && busy_q[bus.p0_rd];
        p0_grant  = bus.p0_valid && !force_m && !p0_hazard;
        m_grant   = bus.m_valid && !p0_grant;

        wr_rd   = p0_grant ? bus.p0_rd : bus.m_rd;
        wr_data = p0_grant ? bus.p0_data : bus.m_data;
        // r0 writes still handshake but never reach the file
        wr_en   = (p0_grant || m_grant) && (wr_rd != 5'd0);
    end

    always_comb begin
        wait_nxt = wait_cnt;
        if (!bus.m_valid || m_grant)
            wait_nxt = '0;
        else if (wait_cnt != LIMIT)
            wait_nxt = wait_cnt + CW'(1);
    end

    always_comb begin
        busy_d = busy_q;
        if (m_grant)
            busy_d[bus.m_rd] = 1'b0;
        // a same-cycle issue to the index being retired keeps it busy
        if (bus.iss_valid)
            busy_d[bus.iss_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt   <= '0;
            busy_q     <= '0;
            rf_we_q    <= 1'b0;
            rf_rd_q    <= 5'd0;
            rf_wdata_q <= 32'd0;
        end else begin
            wait_cnt   <= wait_nxt;
            busy_q     <= busy_d;
            rf_we_q    <= wr_en;
            rf_rd_q    <= wr_en ? wr_rd : 5'd0;
            rf_wdata_q <= wr_en ? wr_data : 32'd0;
        end
    end

    assign bus.p0_stall = bus.p0_valid && !p0_grant;
    assign bus.m_ready  = m_grant;
    assign bus.busy     = busy_q;
    assign bus.rf_we    = rf_we_q;
    assign bus.rf_rd    = rf_rd_q;
    assign bus.rf_wdata = rf_wdata_q;
endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter: grant, starvation,
// scoreboard, r0 and reset behaviour against hand-computed values.
module tb_reg_write_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;

    reg_write_arbiter_if bus ();

    reg_write_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.p0_valid  = 1'b0;
        bus.p0_rd     = 5'd0;
        bus.p0_data   = 32'd0;
        bus.m_valid   = 1'b0;
        bus.m_rd      = 5'd0;
        bus.m_data    = 32'd0;
        bus.iss_valid = 1'b0;
        bus.iss_rd    = 5'd0;
    endtask

    initial begin
        idle();
        #12;
        chk("rst_busy", bus.busy, 32'd0);
        chk("rst_we", {31'd0, bus.rf_we}, 32'd0);
        chk("rst_rd", {27'd0, bus.rf_rd}, 32'd0);
        chk("rst_wdata", bus.rf_wdata, 32'd0);
        bus.p0_valid = 1'b1;
        bus.p0_rd    = 5'd3;
        bus.m_valid  = 1'b1;
        #1;
        chk("rst_mready_p0", {31'd0, bus.m_ready}, 32'd0);
        chk("rst_stall", {31'd0, bus.p0_stall}, 32'd0);
        bus.p0_valid = 1'b0;
        #1;
        chk("rst_mready", {31'd0, bus.m_ready}, 32'd1);
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // plain pipeline write
        bus.p0_valid = 1'b1;
        bus.p0_rd    = 5'd5;
        bus.p0_data  = 32'hAA;
        #1;
        chk("p0_stall", {31'd0, bus.p0_stall}, 32'd0);
        tick();
        chk("p0_we", {31'd0, bus.rf_we}, 32'd1);
        chk("p0_rd", {27'd0, bus.rf_rd}, 32'd5);
        chk("p0_wdata", bus.rf_wdata, 32'hAA);
        idle();
        tick();
        chk("idle_we", {31'd0, bus.rf_we}, 32'd0);
        chk("idle_rd", {27'd0, bus.rf_rd}, 32'd0);
        chk("idle_wdata", bus.rf_wdata, 32'd0);

        // r0 write handshakes but is suppressed
        bus.p0_valid = 1'b1;
        bus.p0_rd    = 5'd0;
        bus.p0_data  = 32'h55;
        #1;
        chk("r0_stall", {31'd0, bus.p0_stall}, 32'd0);
        tick();
        chk("r0_we", {31'd0, bus.rf_we}, 32'd0);
        chk("r0_rd", {27'd0, bus.rf_rd}, 32'd0);
        chk("r0_wdata", bus.rf_wdata, 32'd0);
        idle();

        // m write to a non-busy register
        bus.m_valid = 1'b1;
        bus.m_rd    = 5'd12;
        bus.m_data  = 32'h1234;
        #1;
        chk("m_ready", {31'd0, bus.m_ready}, 32'd1);
        tick();
        chk("m_rd", {27'd0, bus.rf_rd}, 32'd12);
        chk("m_wdata", bus.rf_wdata, 32'h1234);
        idle();
        tick();

        // starvation: refused 4 cycles, forced on the 5th
        bus.p0_valid = 1'b1;
        bus.p0_rd    = 5'd1;
        bus.p0_data  = 32'h11;
        bus.m_valid  = 1'b1;
        bus.m_rd     = 5'd2;
        bus.m_data   = 32'h22;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("starve_mready%0d", i), {31'd0, bus.m_ready}, 32'd0);
            chk($sformatf("starve_stall%0d", i), {31'd0, bus.p0_stall}, 32'd0);
            tick();
            chk($sformatf("starve_rd%0d", i), {27'd0, bus.rf_rd}, 32'd1);
        end
        #1;
        chk("force_mready", {31'd0, bus.m_ready}, 32'd1);
        chk("force_stall", {31'd0, bus.p0_stall}, 32'd1);
        tick();
        chk("force_rd", {27'd0, bus.rf_rd}, 32'd2);
        chk("force_wdata", bus.rf_wdata, 32'h22);
        chk("after_force_mready", {31'd0, bus.m_ready}, 32'd0);
        idle();
        tick();

        // WAW hazard on r7
        bus.iss_valid = 1'b1;
        bus.iss_rd    = 5'd7;
        tick();
        idle();
        chk("busy7", bus.busy, 32'h80);
        bus.p0_valid = 1'b1;
        bus.p0_rd    = 5'd7;
        bus.p0_data  = 32'h77;
        #1;
        chk("haz_stall", {31'd0, bus.p0_stall}, 32'd1);
        tick();
        chk("haz_we", {31'd0, bus.rf_we}, 32'd0);
        chk("haz_stall2", {31'd0, bus.p0_stall}, 32'd1);
        bus.m_valid = 1'b1;
        bus.m_rd    = 5'd7;
        bus.m_data  = 32'h700;
        #1;
        chk("haz_mready", {31'd0, bus.m_ready}, 32'd1);
        chk("haz_stall3", {31'd0, bus.p0_stall}, 32'd1);
        tick();
        chk("haz_mrd", {27'd0, bus.rf_rd}, 32'd7);
        chk("haz_mdata", bus.rf_wdata, 32'h700);
        chk("haz_busy", bus.busy, 32'd0);
        bus.m_valid = 1'b0;
        #1;
        chk("haz_release", {31'd0, bus.p0_stall}, 32'd0);
        tick();
        chk("haz_p0data", bus.rf_wdata, 32'h77);
        idle();

        // set beats clear; r0 never busy
        bus.iss_valid = 1'b1;
        bus.iss_rd    = 5'd9;
        tick();
        chk("busy9", bus.busy, 32'h200);
        bus.m_valid = 1'b1;
        bus.m_rd    = 5'd9;
        bus.m_data  = 32'h99;
        #1;
        chk("set_clr_mready", {31'd0, bus.m_ready}, 32'd1);
        tick();
        chk("set_wins", bus.busy, 32'h200);
        chk("set_clr_rd", {27'd0, bus.rf_rd}, 32'd9);
        bus.m_valid = 1'b0;
        bus.iss_rd  = 5'd0;
        tick();
        chk("busy_r0", bus.busy, 32'h200);
        bus.iss_valid = 1'b0;
        bus.m_valid   = 1'b1;
        tick();
        chk("clr9", bus.busy, 32'd0);
        idle();

        // reset mid-operation
        bus.iss_valid = 1'b1;
        bus.iss_rd    = 5'd3;
        tick();
        idle();
        chk("busy3", bus.busy, 32'h8);
        bus.p0_valid = 1'b1;
        bus.p0_rd    = 5'd1;
        bus.p0_data  = 32'h31;
        bus.m_valid  = 1'b1;
        bus.m_rd     = 5'd4;
        bus.m_data   = 32'h44;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_busy", bus.busy, 32'd0);
        chk("mid_we", {31'd0, bus.rf_we}, 32'd0);
        chk("mid_mready", {31'd0, bus.m_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_we", {31'd0, bus.rf_we}, 32'd0);
        chk("rel_mready0", {31'd0, bus.m_ready}, 32'd0);
        for (int i = 1; i < 4; i++) begin
            tick();
            chk($sformatf("rel_mready%0d", i), {31'd0, bus.m_ready}, 32'd0);
        end
        tick();
        chk("rel_force", {31'd0, bus.m_ready}, 32'd1);
        idle();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got=running exp=done");
        $fatal(1, "timeout");
    end
endmodule
